riscv_imem_apb: RTL and testbench
=================================

RISCV_IMEM_APB -- requirements
Module: riscv_imem_apb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit memory words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of APB wait states inserted per transfer.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 psel_i  input  1  APB select from the fetch master.
REQ-007 penable_i  input  1  APB enable, marking the access phase.
REQ-008 paddr_i  input  32  APB byte address.
REQ-009 pwrite_i  input  1  1 for write, 0 for read.
REQ-010 pwdata_i  input  32  APB write data.
REQ-011 pready_o  output  1  transfer-complete strobe.
REQ-012 prdata_o  output  32  read data, valid only while pready_o=1.
REQ-013 pslverr_o  output  1  error response, valid only while pready_o=1.

Function
REQ-014 The block SHALL be an APB slave with two FSM states, ST_IDLE and ST_ACCESS, plus a wait counter sized to hold WAIT_CYCLES.
REQ-015 In ST_IDLE, psel_i=1 with penable_i=0 (setup) SHALL latch paddr_i, pwrite_i and pwdata_i, load the counter with WAIT_CYCLES, and move to ST_ACCESS.
REQ-016 In ST_IDLE, any other input combination, including psel_i=1 with penable_i=1, SHALL be ignored, and pready_o SHALL be 0.
REQ-017 In ST_ACCESS, pready_o SHALL be combinationally 1 exactly when the counter is 0; otherwise each clock with psel_i=1 and penable_i=1 SHALL decrement the counter.
REQ-018 Latency: a setup sampled in cycle T SHALL give pready_o=1 in cycle T+1+WAIT_CYCLES; with WAIT_CYCLES=0 there SHALL be no wait states.
REQ-019 Completion is any ST_ACCESS cycle with psel_i, penable_i and pready_o all 1; the FSM SHALL return to ST_IDLE on that edge.
REQ-020 Word index = (latched addr - BASE_ADDR) >> 2; the address SHALL be in error if addr[1:0] != 0, addr < BASE_ADDR, or index >= DEPTH.
REQ-021 Read completion without error SHALL drive prdata_o = mem[index] from the latched address, with pslverr_o=0.
REQ-022 Write completion without error SHALL write the latched pwdata into mem[index] on the completing edge; prdata_o SHALL be 0.
REQ-023 Error completion SHALL drive pslverr_o=1 and prdata_o=0, and SHALL leave the memory unmodified.
REQ-024 prdata_o and pslverr_o SHALL be 0 whenever pready_o=0.
REQ-025 If psel_i drops in ST_ACCESS before completion (master abort), the FSM SHALL return to ST_IDLE on that edge, with no memory write and no response.
REQ-026 A new setup SHALL be accepted only from ST_IDLE; this gives back-to-back transfers of at least 2+WAIT_CYCLES cycles each.

Reset
REQ-027 While reset=1 at a clock edge, the FSM SHALL go to ST_IDLE, the counter SHALL clear to 0, and every memory word SHALL load 32'h0000_0013 (RISC-V NOP).
REQ-028 Outputs after reset SHALL be pready_o=0, prdata_o=0 and pslverr_o=0.
REQ-029 Reset SHALL take priority over any transfer in flight, and a write aborted by reset SHALL NOT modify memory.

Verification
REQ-030 All scenarios use the defaults (DEPTH=256, WAIT_CYCLES=2, BASE_ADDR=0), and a checker SHALL flag any REQ-024 violation in every scenario.
REQ-031 Read reset contents: after reset, read 0x0000_0010 with setup in cycle T -> pready_o=0 in T+1 and T+2, then pready_o=1 in T+3 with prdata_o=0x0000_0013 and pslverr_o=0.
REQ-032 Write then read: write 0x0050_0093 to 0x0000_0004, then read 0x0000_0004 -> both complete with pslverr_o=0, and the read returns 0x0050_0093.
REQ-033 Out of range: read 0x0000_0400 (index 256) -> pready_o=1 in T+3 with pslverr_o=1 and prdata_o=0.
REQ-034 Misaligned write: write 0xDEAD_BEEF to 0x0000_0006 -> pslverr_o=1; a following read of 0x0000_0004 returns its prior value.
REQ-035 Reset mid-write: write 0x1234_5678 to 0x0000_0008, assert reset in the first access cycle -> next cycle pready_o=0; a later read of 0x0000_0008 returns 0x0000_0013.
REQ-036 Master abort: drop psel_i in the second access cycle of a write to 0x0000_000C -> no pready_o, no memory change; the next read of 0x0000_000C completes normally with 0x0000_0013.

Source files
------------

// File: rtl/riscv_imem_apb.sv
// riscv_imem_apb: word-addressed instruction memory behind an APB slave port.
// Each transfer waits WAIT_CYCLES access cycles before completing. Reset
// fills the whole array with the RISC-V NOP so a fetch from a freshly reset
// memory executes harmlessly.
module riscv_imem_apb #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);
    localparam logic [31:0]      NOP_WORD  = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      addr_q;
    logic             write_q;
    logic [31:0]      wdata_q;

    logic [31:0] mem [DEPTH];

    // Address decode, always taken from the address latched at setup.
    logic [31:0]      offset;
    logic [31:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             addr_err;
    logic             complete;
    logic             mem_we;

    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      (addr_q < BASE_ADDR) ||
                      (word_idx >= DEPTH_W);

    // The wait counter reaching zero is the ready condition; it is not registered.
    assign pready_o = (state == ST_ACCESS) && (wait_cnt == '0);
    assign complete = pready_o && psel_i && penable_i;
    assign mem_we   = complete && write_q && !addr_err;

    // Transfer sequencing: latch the request at setup, count wait states,
    // return to idle on completion or when the master drops psel_i.
    always_ff @(posedge clk) begin
        // NOTE: all state here is assigned with <= so every register samples
        // the pre-edge values; a blocking = would let later lines see
        // already-updated state and break the counter/state handshake.
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        addr_q   <= paddr_i;
                        write_q  <= pwrite_i;
                        wdata_q  <= pwdata_i;
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!psel_i || complete) begin
                        state <= ST_IDLE;
                    end else if (penable_i && (wait_cnt != '0)) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory array: whole-array NOP fill on reset, single-word write on a
    // clean write completion.
    always_ff @(posedge clk) begin
        // NOTE: this memory is deliberately reset word by word, which forces
        // it into flops rather than a RAM macro; that is the price of the
        // guaranteed NOP contents after reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    // Response data: zero unless ready, error flag or read data while ready.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (pready_o) begin
            if (addr_err) begin
                pslverr_o = 1'b1;
            end else if (!write_q) begin
                prdata_o = mem[mem_idx];
            end
        end
    end

endmodule

// File: tb/tb_riscv_imem_apb.sv
// tb_riscv_imem_apb: self-checking bench for riscv_imem_apb at default
// parameters. Directed table, hand-built corner sequences, then random
// traffic checked against an array model of the memory.
module tb_riscv_imem_apb;

    localparam int          DEPTH       = 256;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam int          BUDGET      = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    riscv_imem_apb #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .psel_i   (psel),
        .penable_i(penable),
        .paddr_i  (paddr),
        .pwrite_i (pwrite),
        .pwdata_i (pwdata),
        .pready_o (pready),
        .prdata_o (prdata),
        .pslverr_o(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Response data must be quiet whenever ready is low, in every scenario.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ((pready !== 1'b1) && ((prdata !== 32'h0) || (pslverr !== 1'b0))) begin
                n_fail++;
                $display("FAIL quiet_when_not_ready: pready %b prdata %h pslverr %b at %0t",
                         pready, prdata, pslverr, $time);
            end
        end
    end

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        psel    = s;
        penable = e;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP_WORD;
    endfunction

    function automatic logic model_bad(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE_ADDR);
        return (a % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b1;
        model_reset();
    endtask

    // One complete transfer; lat counts access cycles up to and including the ready cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
        bit done;
        done  = 0;
        rdata = '0;
        err   = 1'b0;
        lat   = 0;
        step();
        drive(1'b1, 1'b0, wr, addr, wdata);
        for (int n = 1; n <= BUDGET && !done; n++) begin
            step();
            drive(1'b1, 1'b1, wr, addr, wdata);
            #1;
            if (pready === 1'b1) begin
                rdata = prdata;
                err   = pslverr;
                lat   = n;
                done  = 1;
            end
        end
        if (!done) check("xfer_timeout", 32'h0, 32'h1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Transfer abandoned after k access cycles by dropping psel.
    task automatic apb_abort(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int k);
        step();
        drive(1'b1, 1'b0, wr, addr, wdata);
        for (int n = 1; n <= k; n++) begin
            step();
            drive(1'b1, 1'b1, wr, addr, wdata);
            #1;
            check("abort_no_ready", 32'(pready), 32'h0);
        end
        step();
        drive(1'b0, 1'b0, wr, addr, wdata);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Run a transfer and compare against the model's prediction, then update the model.
    task automatic xfer_and_check(input string tag, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = model_bad(addr);
        exp_rd  = (exp_err || wr) ? 32'h0 : model_mem[(addr - BASE_ADDR) / 4];
        apb_xfer(wr, addr, wdata, rdata, err, lat);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_latency"}, 32'(lat), 32'(1 + WAIT_CYCLES));
        if (wr && !exp_err) model_mem[(addr - BASE_ADDR) / 4] = wdata;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h0000_0013};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0050_0093,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,          1'b0, 32'h0050_0093};
        vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,          1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0006, 32'hDEAD_BEEF,  1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,          1'b0, 32'h0050_0093};
        vecs[6]  = '{1'b0, 32'h0000_03FC, 32'h0,          1'b0, 32'h0000_0013};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,          1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'h0000_0001, 32'h0,          1'b1, 32'h0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'h1111_2222,  1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0000_0013};

        do_reset();

        // Outputs straight after reset.
        check("reset_pready", 32'(pready), 32'h0);
        check("reset_prdata", prdata, 32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);

        // Cycle-exact read of reset contents: ready exactly in T+3.
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        #1 check("lat_T1_pready", 32'(pready), 32'h0);
        step();
        #1 check("lat_T2_pready", 32'(pready), 32'h0);
        step();
        #1 check("lat_T3_pready", 32'(pready), 32'h1);
        check("lat_T3_prdata", prdata, NOP_WORD);
        check("lat_T3_pslverr", 32'(pslverr), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("after_complete_pready", 32'(pready), 32'h0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(1 + WAIT_CYCLES));
            if (vecs[i].wr && !vecs[i].exp_err) model_mem[vecs[i].addr / 4] = vecs[i].wdata;
        end

        // psel with penable from idle is not a setup and must be ignored.
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
            #1 check("idle_access_ignored", 32'(pready), 32'h0);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        xfer_and_check("idle_ignore_read", 1'b0, 32'h0000_0020, 32'h0);

        // Reset during the first access cycle of a write.
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        mon_en = 1'b1;
        model_reset();
        #1 check("reset_mid_write_pready", 32'(pready), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("reset_mid_write_idle", 32'(pready), 32'h0);
        xfer_and_check("reset_mid_write_read", 1'b0, 32'h0000_0008, 32'h0);
        xfer_and_check("reset_cleared_vec", 1'b0, 32'h0000_0004, 32'h0);

        // Master abort in the second access cycle of a write.
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'hAAAA_5555);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'hAAAA_5555);
        #1 check("abort_T1_pready", 32'(pready), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'hAAAA_5555);
        #1 check("abort_T2_pready", 32'(pready), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("abort_T3_pready", 32'(pready), 32'h0);
        xfer_and_check("abort_read", 1'b0, 32'h0000_000C, 32'h0);

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          sel;
            int          gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            sel   = $urandom_range(0, 9);
            if (sel < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (sel == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1023)) * 4;
            else               addr = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                apb_abort(wr, addr, wdata, $urandom_range(1, 2));
            end else begin
                xfer_and_check("rand", wr, addr, wdata);
            end
        end

        // Sweep a few words to confirm the model and memory still agree.
        for (int i = 0; i < 16; i++) begin
            xfer_and_check("final_sweep", 1'b0, 32'($urandom_range(0, DEPTH - 1)) * 4, 32'h0);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
